up_interp_lin: RTL and testbench
================================

// Module: up_interp_lin
// PURPOSE
//  Linear-interpolating upsampler: inverse of the growing/down-averaging path.
//  - Accepts decimated unsigned samples on a valid/ready input.
//  - Emits R = 2**LOG2_R output samples per input, one per clk.
//  - Outputs step linearly from the previous sample toward the current one.
//  - Restores the full-rate stream ahead of the DAC/tone side of the gateware.
// PARAMETERS
//  N       16  sample width, unsigned, for input and output
//  LOG2_R  1   log2 of the upsample ratio; R = 2**LOG2_R; legal range 1..8
// PORTS
//  clk      in   1   sole clock, rising edge
//  rst      in   1   asynchronous, active-high reset
//  x        in   N   input sample, unsigned
//  x_valid  in   1   x holds a sample this cycle
//  x_ready  out  1   block accepts x this cycle; accept = x_valid & x_ready at posedge
//  y        out  N   interpolated sample, registered
//  y_valid  out  1   y is new this cycle; no output backpressure (sink always accepts)
// BEHAVIOUR
//  Reset
//   - rst asserted, any cycle: state=IDLE; a, b, acc, d, k all 0; y=0; y_valid=0.
//   - A partial interpolation run is discarded and nothing further is emitted.
//   - Outputs resume only after two new accepts.
//  Registers
//   - a, b: previous and current samples (N bits).
//   - d = b - a: signed, N+1 bits.
//   - acc: signed, N+LOG2_R+1 bits.
//   - k: phase counter, LOG2_R bits.
//  States
//   - IDLE: no samples held. x_ready=1. Accept: a<=x, go to PRIME. No output.
//   - PRIME: one sample held in a. x_ready=1.
//     Accept: b<=x, d<=x-a, acc<=a<<LOG2_R, k<=0, go to RUN.
//   - RUN: every cycle y<=acc[N+LOG2_R-1:LOG2_R], y_valid<=1, acc<=acc+d, k<=k+1.
//     x_ready=(k==R-1), combinational from state and k.
//     At k==R-1 with accept: a<=b, b<=x, d<=x-b, acc<=b<<LOG2_R, k<=0, stay in RUN.
//     At k==R-1 without accept: a<=b, go to PRIME. This is a stall; y_valid falls next cycle.
//   - y_valid is 0 in IDLE and PRIME.
//  Output sequence and arithmetic
//   - Output k of a run = a + floor(k*(b-a)/R), k=0..R-1, with floor toward -inf.
//   - y holds its last value when y_valid=0.
//   - acc stays within [0, (2**N-1)<<LOG2_R], so there is no overflow or saturation.
//  Timing
//   - Latency: the accept of b at edge t gives first output y=a with y_valid=1 at edge t+1.
//   - With x_valid held high, throughput is exactly 1 input per R clocks.
//   - y_valid stays continuously high, with no bubble between runs.
//  Boundary conditions
//   - x_valid ignored whenever x_ready=0; x need not be held stable while not ready.
//   - Equal consecutive samples (d=0) give R copies of a.
//   - Full-scale swings 0 <-> 2**N-1 are exact at k=0.
//   - The final input sample is never emitted by itself. Its value appears as a
//     of the next run, so the stream lags by one input sample.
// TESTING
//  1. N=16, LOG2_R=1, x_valid=1, x=0,10,20,20,... -> y=0,5,10,15,20,20,...;
//     y_valid continuous from the cycle after the 2nd accept.
//  2. LOG2_R=2, x=0 then 10 -> y=0,2,5,7. Then x=0 -> y=10,7,5,2 (floor on descending ramp).
//  3. LOG2_R=2, x=65535 then 0 -> y=65535,49151,32767,16383. Then 65535 -> 0,16383,32767,49151.
//     Checks no overflow at full scale.
//  4. LOG2_R=1, x=4,8 then x_valid=0 for 5 cycles, then x=12 ->
//     y=4,6; y_valid=0 during the gap; then y=8,10 with a=8 retained.
//  5. rst pulsed mid-RUN, asynchronous between edges ->
//     y=0, y_valid=0 and x_ready=1 immediately; the next two accepts re-prime.
//  6. Ramp x=i for i=0..1023, LOG2_R=1 ->
//     y = 0,0,1,1,2,2,... (floor of (2i+k)/2) with 2048 valids less priming; x_ready duty 1/2.

Source files
------------

// File: rtl/up_interp_lin.sv
// Linear-interpolating upsampler: each accepted sample b, paired with the previous sample a,
// produces R = 2**LOG2_R outputs stepping from a toward b, one per clock.
module up_interp_lin #(
  parameter int N      = 16,
  parameter int LOG2_R = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [N-1:0] y,
  output logic         y_valid
);

  localparam int AW = N + LOG2_R + 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                 state_q, state_d;
  logic [N-1:0]           a_q, a_d;
  logic [N-1:0]           b_q, b_d;
  logic signed [N:0]      d_q, d_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [LOG2_R-1:0]      k_q, k_d;
  logic [N-1:0]           y_q, y_d;
  logic                   y_valid_q, y_valid_d;

  logic                   last_phase;
  logic                   accept;

  assign last_phase = &k_q;
  assign x_ready    = (state_q != RUN) || last_phase;
  assign accept     = x_valid && x_ready;
  assign y          = y_q;
  assign y_valid    = y_valid_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    d_d       = d_q;
    acc_d     = acc_q;
    k_d       = k_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = x;
          state_d = PRIME;
        end
      end
      PRIME: begin
        if (accept) begin
          b_d     = x;
          d_d     = $signed({1'b0, x}) - $signed({1'b0, a_q});
          acc_d   = {1'b0, a_q, {LOG2_R{1'b0}}};
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // acc holds (a<<LOG2_R) + k*d, so its upper bits are a + floor(k*d/R)
        y_d       = acc_q[N+LOG2_R-1:LOG2_R];
        y_valid_d = 1'b1;
        acc_d     = acc_q + AW'(d_q);
        k_d       = k_q + LOG2_R'(1);
        if (last_phase) begin
          a_d = b_q;
          if (accept) begin
            b_d   = x;
            d_d   = $signed({1'b0, x}) - $signed({1'b0, b_q});
            acc_d = {1'b0, b_q, {LOG2_R{1'b0}}};
            k_d   = '0;
          end else begin
            state_d = PRIME;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      d_q       <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      d_q       <= d_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

endmodule

// File: tb/tb_up_interp_lin.sv
// Bench for up_interp_lin: one instance at R=2 and one at R=4, checked every cycle against
// a queue model of the expected interpolated stream plus hand-computed literal sequences.
module tb_up_interp_lin;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] x_s  [2];
  logic        xv_s [2];
  logic        xr_s [2];
  logic [15:0] y_s  [2];
  logic        yv_s [2];

  int checks = 0;
  int errors = 0;

  int r_of  [2] = '{2, 4};
  int exp_q [2][$];
  int got   [2][$];
  int have_prev [2];
  int prev_x    [2];
  int last_y    [2];
  int exp_list  [$];

  always #5 clk = ~clk;

  up_interp_lin #(.N(16), .LOG2_R(1)) dut1 (
    .clk(clk), .rst(rst), .x(x_s[0]), .x_valid(xv_s[0]), .x_ready(xr_s[0]),
    .y(y_s[0]), .y_valid(yv_s[0])
  );

  up_interp_lin #(.N(16), .LOG2_R(2)) dut2 (
    .clk(clk), .rst(rst), .x(x_s[1]), .x_valid(xv_s[1]), .x_ready(xr_s[1]),
    .y(y_s[1]), .y_valid(yv_s[1])
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, req);
    end
  endtask

  // a + floor(k*(b-a)/r), rounding toward minus infinity
  function automatic int interp(input int a, input int b, input int k, input int r);
    int num;
    int q;
    num = k * (b - a);
    q   = num / r;
    if ((num % r) != 0 && num < 0) q = q - 1;
    return a + q;
  endfunction

  always @(posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      got[i].delete();
      have_prev[i] = 0;
      last_y[i]    = 0;
    end
  end

  // Compare process: inputs sampled just before each edge, outputs checked 1 time unit after.
  initial begin
    int acc_c [2];
    int xin   [2];
    int e;
    for (int i = 0; i < 2; i++) begin
      have_prev[i] = 0;
      last_y[i]    = 0;
    end
    forever begin
      @(negedge clk);
      #4;
      for (int i = 0; i < 2; i++) begin
        acc_c[i] = (!rst && xv_s[i] && xr_s[i]) ? 1 : 0;
        xin[i]   = int'(x_s[i]);
      end
      @(posedge clk);
      #1;
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          if (exp_q[i].size() > 0) begin
            e = exp_q[i].pop_front();
            chk($sformatf("yvalid_run%0d", i), int'(yv_s[i]), 1);
            chk($sformatf("y%0d", i), int'(y_s[i]), e);
            last_y[i] = e;
            got[i].push_back(int'(y_s[i]));
          end else begin
            chk($sformatf("yvalid_idle%0d", i), int'(yv_s[i]), 0);
            chk($sformatf("y_hold%0d", i), int'(y_s[i]), last_y[i]);
          end
          if (acc_c[i] != 0) begin
            if (have_prev[i] != 0)
              for (int k = 0; k < r_of[i]; k++)
                exp_q[i].push_back(interp(prev_x[i], xin[i], k, r_of[i]));
            have_prev[i] = 1;
            prev_x[i]    = xin[i];
          end
          chk($sformatf("x_ready%0d", i), int'(xr_s[i]), (exp_q[i].size() <= 1) ? 1 : 0);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with x_valid still high.
  task automatic send(input int i, input int v);
    int n;
    n = 0;
    xv_s[i] = 1'b1;
    while (!xr_s[i] && n < 16) begin
      x_s[i] = 16'($urandom);
      @(negedge clk);
      n++;
    end
    if (!xr_s[i]) chk($sformatf("send_ready%0d", i), int'(xr_s[i]), 1);
    x_s[i] = 16'(v);
    @(negedge clk);
    $display("dut%0d accept x=%0d", i, v);
  endtask

  task automatic idle(input int i, input int n);
    xv_s[i] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    xv_s[0] = 1'b0;
    xv_s[1] = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_y%0d", i), int'(y_s[i]), 0);
      chk($sformatf("rst_yvalid%0d", i), int'(yv_s[i]), 0);
      chk($sformatf("rst_xready%0d", i), int'(xr_s[i]), 1);
    end
    rst = 1'b0;
  endtask

  task automatic check_log(input int i, input string nm);
    chk($sformatf("%s_count", nm), got[i].size(), exp_list.size());
    for (int j = 0; j < exp_list.size(); j++)
      if (j < got[i].size())
        chk($sformatf("%s_y%0d", nm, j), got[i][j], exp_list[j]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    x_s[0] = '0; x_s[1] = '0;
    xv_s[0] = 1'b0; xv_s[1] = 1'b0;

    // Continuous valid at R=2
    do_reset();
    send(0, 0); send(0, 10); send(0, 20); send(0, 20); send(0, 20);
    idle(0, 5);
    exp_list = '{0, 5, 10, 15, 20, 20, 20, 20};
    check_log(0, "ramp_r2");

    // R=4 ascending then descending ramp (floor on the way down)
    do_reset();
    send(1, 0); send(1, 10); send(1, 0);
    idle(1, 7);
    exp_list = '{0, 2, 5, 7, 10, 7, 5, 2};
    check_log(1, "updown_r4");

    // Full-scale swings at R=4
    do_reset();
    send(1, 65535); send(1, 0); send(1, 65535);
    idle(1, 7);
    exp_list = '{65535, 49151, 32767, 16383, 0, 16383, 32767, 49151};
    check_log(1, "fullscale_r4");

    // Input gap: stall to PRIME, a retained
    do_reset();
    send(0, 4); send(0, 8);
    idle(0, 5);
    send(0, 12);
    idle(0, 5);
    exp_list = '{4, 6, 8, 10};
    check_log(0, "gap_r2");

    // Asynchronous reset in the middle of a run
    do_reset();
    send(1, 100); send(1, 200);
    xv_s[1] = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_rst_yvalid", int'(yv_s[1]), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_y", int'(y_s[1]), 0);
    chk("async_rst_yvalid", int'(yv_s[1]), 0);
    chk("async_rst_xready", int'(xr_s[1]), 1);
    @(negedge clk);
    rst = 1'b0;
    send(1, 8); send(1, 4);
    idle(1, 7);
    exp_list = '{8, 7, 6, 5};
    check_log(1, "reprime_r4");

    // Long ramp at R=2
    do_reset();
    for (int v = 0; v < 1024; v++) send(0, v);
    idle(0, 5);
    chk("long_count", got[0].size(), 2046);
    if (got[0].size() == 2046) begin
      chk("long_y3", got[0][3], 1);
      chk("long_y1000", got[0][1000], 500);
      chk("long_ylast", got[0][2045], 1022);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
